// File: rtl/mmio_port_responder.sv
// Memory-mapped I/O responder for a single-cycle processor data path.
// Word registers live in a 32-byte window at BASE_ADDR: an output port,
// a synchronized input port with change detection, a sticky status
// register that clears when read, and a down-counting interval timer.
module mmio_port_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h1002_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] ReadData,
  output logic        Hit,
  input  logic [7:0]  PortIn,
  output logic [31:0] PortOut,
  output logic        TimerIRQ
);

  // Word offsets within the window (byte offset >> 2).
  localparam logic [2:0] OFF_PORT_OUT    = 3'd0;
  localparam logic [2:0] OFF_PORT_IN     = 3'd1;
  localparam logic [2:0] OFF_STATUS      = 3'd2;
  localparam logic [2:0] OFF_TIMER_LOAD  = 3'd3;
  localparam logic [2:0] OFF_TIMER_CTRL  = 3'd4;
  localparam logic [2:0] OFF_TIMER_COUNT = 3'd5;

  // The timer's enable bit is its state: idle holds the count, run counts down.
  typedef enum logic {
    T_IDLE = 1'b0,
    T_RUN  = 1'b1
  } timer_state_e;

  // Address decode. BASE_ADDR is word aligned, so the low bits of the
  // relative address match the low bits of Address.
  logic [31:0] rel_addr;
  logic [2:0]  word_off;
  logic        in_window;
  logic        aligned;

  assign rel_addr  = Address - BASE_ADDR;
  assign word_off  = rel_addr[4:2];
  assign in_window = (rel_addr[31:5] == 27'd0);
  assign aligned   = (rel_addr[1:0] == 2'b00);
  assign Hit       = in_window && aligned;

  // State registers and their next values.
  logic [31:0]  port_out_q, port_out_d;
  logic [7:0]   s1_q, s1_d;
  logic [7:0]   s2_q, s2_d;
  logic [7:0]   prev_q, prev_d;
  logic         in_changed_q, in_changed_d;
  logic         timer_expired_q, timer_expired_d;
  logic [31:0]  timer_load_q, timer_load_d;
  timer_state_e state_q, state_d;
  logic         auto_reload_q, auto_reload_d;
  logic [31:0]  count_q, count_d;

  logic wr_hit;
  logic status_clear;
  logic terminal;
  logic changed_set;

  assign wr_hit       = MemWrite && Hit;
  assign status_clear = MemRead && Hit && (word_off == OFF_STATUS);
  assign terminal     = (state_q == T_RUN) && (count_q == 32'd0);
  assign changed_set  = (s2_q != prev_q);

  // Next-state logic: bus writes, input synchronizer, status flags and timer.
  always_comb begin
    port_out_d      = port_out_q;
    s1_d            = PortIn;
    s2_d            = s1_q;
    prev_d          = s2_q;
    timer_load_d    = timer_load_q;
    state_d         = state_q;
    auto_reload_d   = auto_reload_q;
    count_d         = count_q;

    // A flag set in the same cycle as a clearing read survives the read.
    in_changed_d    = changed_set | (in_changed_q    & ~status_clear);
    timer_expired_d = terminal    | (timer_expired_q & ~status_clear);

    unique case (state_q)
      T_IDLE: ;
      T_RUN: begin
        if (count_q != 32'd0) begin
          count_d = count_q - 32'd1;
        end else if (auto_reload_q) begin
          count_d = timer_load_q;
        end else begin
          state_d = T_IDLE;
        end
      end
      default: state_d = T_IDLE;
    endcase

    // Bus writes come last so they override the timer's own update.
    if (wr_hit) begin
      unique case (word_off)
        OFF_PORT_OUT: port_out_d = WriteData;
        OFF_TIMER_LOAD: begin
          timer_load_d = WriteData;
          count_d      = WriteData;
        end
        OFF_TIMER_CTRL: begin
          state_d       = WriteData[0] ? T_RUN : T_IDLE;
          auto_reload_d = WriteData[1];
        end
        default: ;
      endcase
    end
  end

  // State update with asynchronous clear of every register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      port_out_q      <= 32'd0;
      s1_q            <= 8'd0;
      s2_q            <= 8'd0;
      prev_q          <= 8'd0;
      in_changed_q    <= 1'b0;
      timer_expired_q <= 1'b0;
      timer_load_q    <= 32'd0;
      state_q         <= T_IDLE;
      auto_reload_q   <= 1'b0;
      count_q         <= 32'd0;
    end else begin
      port_out_q      <= port_out_d;
      s1_q            <= s1_d;
      s2_q            <= s2_d;
      prev_q          <= prev_d;
      in_changed_q    <= in_changed_d;
      timer_expired_q <= timer_expired_d;
      timer_load_q    <= timer_load_d;
      state_q         <= state_d;
      auto_reload_q   <= auto_reload_d;
      count_q         <= count_d;
    end
  end

  // Zero-latency load data; misses and unused offsets read as zero.
  always_comb begin
    ReadData = 32'd0;
    if (Hit) begin
      unique case (word_off)
        OFF_PORT_OUT:    ReadData = port_out_q;
        OFF_PORT_IN:     ReadData = {24'd0, s2_q};
        OFF_STATUS:      ReadData = {30'd0, timer_expired_q, in_changed_q};
        OFF_TIMER_LOAD:  ReadData = timer_load_q;
        OFF_TIMER_CTRL:  ReadData = {30'd0, auto_reload_q, (state_q == T_RUN)};
        OFF_TIMER_COUNT: ReadData = count_q;
        default:         ReadData = 32'd0;
      endcase
    end
  end

  assign PortOut  = port_out_q;
  assign TimerIRQ = timer_expired_q;

endmodule

// File: tb/tb_mmio_port_responder.sv
// Directed bench for mmio_port_responder: bus writes/reads, input port
// synchronization, status read-to-clear, timer modes and reset behaviour.
module tb_mmio_port_responder;

  localparam logic [31:0] BASE  = 32'h1002_0000;
  localparam logic [31:0] A_OUT = BASE + 32'h00;
  localparam logic [31:0] A_IN  = BASE + 32'h04;
  localparam logic [31:0] A_ST  = BASE + 32'h08;
  localparam logic [31:0] A_LD  = BASE + 32'h0C;
  localparam logic [31:0] A_CT  = BASE + 32'h10;
  localparam logic [31:0] A_CNT = BASE + 32'h14;
  localparam logic [31:0] A_R18 = BASE + 32'h18;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] ReadData;
  logic        Hit;
  logic [7:0]  PortIn;
  logic [31:0] PortOut;
  logic        TimerIRQ;

  int checks   = 0;
  int failures = 0;

  mmio_port_responder #(.BASE_ADDR(BASE)) dut (
    .clk      (clk),
    .reset    (reset),
    .Address  (Address),
    .WriteData(WriteData),
    .MemWrite (MemWrite),
    .MemRead  (MemRead),
    .ReadData (ReadData),
    .Hit      (Hit),
    .PortIn   (PortIn),
    .PortOut  (PortOut),
    .TimerIRQ (TimerIRQ)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Combinational peek at a register (no MemRead, so no side effects).
  task automatic peek(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    Address = addr;
    #1;
    chk(tag, ReadData, exp);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    Address   = addr;
    WriteData = data;
    MemWrite  = 1'b1;
    tick();
    MemWrite  = 1'b0;
    $display("wr addr=0x%08h data=0x%08h", addr, data);
  endtask

  // Load with MemRead: checks the returned data, then takes the edge.
  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    Address = addr;
    MemRead = 1'b1;
    #1;
    chk(tag, ReadData, exp);
    $display("rd addr=0x%08h data=0x%08h", addr, ReadData);
    tick();
    MemRead = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    Address   = A_OUT;
    WriteData = 32'd0;
    MemWrite  = 1'b0;
    MemRead   = 1'b0;
    PortIn    = 8'h00;

    #3;
    chk("rst_portout", PortOut, 32'd0);
    chk("rst_irq", {31'd0, TimerIRQ}, 32'd0);
    chk("rst_rd_out", ReadData, 32'd0);
    ticks(1);
    reset = 1'b0;
    tick();

    // Output port write and read back.
    wr(A_OUT, 32'hA5A5_0001);
    chk("portout_wr", PortOut, 32'hA5A5_0001);
    peek("rd_portout", A_OUT, 32'hA5A5_0001);
    chk("hit_out", {31'd0, Hit}, 32'd1);

    // Misaligned and out-of-window accesses are ignored.
    Address = BASE + 32'h02;
    #1;
    chk("hit_misaligned", {31'd0, Hit}, 32'd0);
    chk("rd_misaligned", ReadData, 32'd0);
    wr(BASE + 32'h02, 32'h0000_DEAD);
    wr(BASE + 32'h40, 32'h0000_BEEF);
    Address = BASE + 32'h40;
    #1;
    chk("hit_outside", {31'd0, Hit}, 32'd0);
    chk("rd_outside", ReadData, 32'd0);
    chk("portout_kept", PortOut, 32'hA5A5_0001);
    wr(A_CNT, 32'h1234);
    peek("cnt_ro", A_CNT, 32'd0);
    wr(A_R18, 32'hFFFF_FFFF);
    peek("rd_18", A_R18, 32'd0);

    // Input port synchronization and change detection.
    PortIn = 8'h3C;
    tick();
    peek("portin_1edge", A_IN, 32'd0);
    tick();
    peek("portin_2edge", A_IN, 32'h3C);
    peek("status_2edge", A_ST, 32'd0);
    tick();
    peek("status_3edge", A_ST, 32'h1);
    rd("status_rd1", A_ST, 32'h1);
    rd("status_rd2", A_ST, 32'h0);

    // Auto-reload timer: LOAD=3, period 4.
    wr(A_LD, 32'd3);
    peek("cnt_loaded", A_CNT, 32'd3);
    wr(A_CT, 32'h3);
    peek("cnt_e0", A_CNT, 32'd3);
    tick(); peek("cnt_e1", A_CNT, 32'd2);
    tick(); peek("cnt_e2", A_CNT, 32'd1);
    tick(); peek("cnt_e3", A_CNT, 32'd0);
    chk("irq_e3", {31'd0, TimerIRQ}, 32'd0);
    tick(); peek("cnt_e4", A_CNT, 32'd3);
    chk("irq_e4", {31'd0, TimerIRQ}, 32'd1);
    peek("ctrl_ar", A_CT, 32'h3);
    rd("status_timer", A_ST, 32'h2);
    chk("irq_cleared", {31'd0, TimerIRQ}, 32'd0);
    peek("cnt_after_rd", A_CNT, 32'd2);
    ticks(2);
    chk("irq_before_2nd", {31'd0, TimerIRQ}, 32'd0);
    tick();
    chk("irq_2nd", {31'd0, TimerIRQ}, 32'd1);
    peek("cnt_reload2", A_CNT, 32'd3);

    // Status read coincident with the terminal cycle: set wins.
    ticks(3);
    peek("cnt_term", A_CNT, 32'd0);
    rd("status_coinc", A_ST, 32'h2);
    chk("irq_set_wins", {31'd0, TimerIRQ}, 32'd1);
    rd("status_after", A_ST, 32'h2);
    chk("irq_clr_after", {31'd0, TimerIRQ}, 32'd0);
    wr(A_CT, 32'h0);
    peek("cnt_stop", A_CNT, 32'd1);
    tick();
    peek("cnt_idle_hold", A_CNT, 32'd1);

    // One-shot timer: LOAD=2.
    wr(A_LD, 32'd2);
    wr(A_CT, 32'h1);
    ticks(2);
    chk("os_irq_pre", {31'd0, TimerIRQ}, 32'd0);
    tick();
    chk("os_irq", {31'd0, TimerIRQ}, 32'd1);
    peek("os_ctrl", A_CT, 32'd0);
    peek("os_cnt", A_CNT, 32'd0);
    rd("os_status", A_ST, 32'h2);
    ticks(5);
    chk("os_no_more", {31'd0, TimerIRQ}, 32'd0);
    peek("os_cnt_hold", A_CNT, 32'd0);

    // CTRL write at the terminal edge keeps the timer enabled.
    wr(A_LD, 32'd1);
    wr(A_CT, 32'h1);
    tick();
    peek("tw_cnt0", A_CNT, 32'd0);
    wr(A_CT, 32'h1);
    chk("tw_irq", {31'd0, TimerIRQ}, 32'd1);
    peek("tw_ctrl_kept", A_CT, 32'h1);
    tick();
    peek("tw_ctrl_clr", A_CT, 32'h0);
    rd("tw_status", A_ST, 32'h2);

    // LOAD write overrides the running decrement.
    wr(A_LD, 32'd10);
    wr(A_CT, 32'h1);
    tick();
    peek("ov_cnt9", A_CNT, 32'd9);
    wr(A_LD, 32'd7);
    peek("ov_cnt7", A_CNT, 32'd7);
    tick();
    peek("ov_cnt6", A_CNT, 32'd6);
    tick();
    peek("ov_cnt5", A_CNT, 32'd5);

    // Asynchronous reset mid-count.
    reset = 1'b1;
    #1;
    chk("ar_portout", PortOut, 32'd0);
    chk("ar_irq", {31'd0, TimerIRQ}, 32'd0);
    peek("ar_cnt", A_CNT, 32'd0);
    peek("ar_ld", A_LD, 32'd0);
    peek("ar_ctrl", A_CT, 32'd0);
    peek("ar_portin", A_IN, 32'd0);
    peek("ar_status", A_ST, 32'd0);
    PortIn = 8'h00;
    ticks(2);
    reset = 1'b0;
    wr(A_OUT, 32'h55);
    chk("post_rst_wr", PortOut, 32'h55);
    ticks(8);
    chk("post_rst_irq", {31'd0, TimerIRQ}, 32'd0);
    peek("post_rst_cnt", A_CNT, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mmio_port_responder.md
MMIO_PORT_RESPONDER -- requirements
Module: mmio_port_responder

Interface
REQ-001 Parameter BASE_ADDR, default 32'h1002_0000: byte address of register offset 0x00; the I/O window is BASE_ADDR..BASE_ADDR+0x1F.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 Address  input  32  byte address from the processor data path (ALU result).
REQ-005 WriteData  input  32  store data (rt register value).
REQ-006 MemWrite  input  1  store strobe, sampled at the rising edge.
REQ-007 MemRead  input  1  load strobe; qualifies read side effects.
REQ-008 ReadData  output  32  combinational load data.
REQ-009 Hit  output  1  combinational; 1 when Address is word-aligned and inside the window, for the processor's load-data mux.
REQ-010 PortIn  input  8  asynchronous external input pins.
REQ-011 PortOut  output  32  registered output port.
REQ-012 TimerIRQ  output  1  equals STATUS[1].

Function
REQ-013 Register map (word offsets): 0x00 PORT_OUT (RW); 0x04 PORT_IN (RO, {24'b0, in_sync}); 0x08 STATUS (RO, read-to-clear: bit0 in_changed, bit1 timer_expired, bits 31:2 read 0); 0x0C TIMER_LOAD (RW, 32-bit); 0x10 TIMER_CTRL (RW, bit0 enable, bit1 auto_reload, bits 31:2 read 0); 0x14 TIMER_COUNT (RO); 0x18 and 0x1C read 0, writes are ignored.
REQ-014 Access with Hit=0 (misaligned or outside the window): ReadData=0, no state change.
REQ-015 ReadData is selected combinationally from Address with zero latency, independent of MemRead.
REQ-016 A write takes effect at the rising edge where MemWrite=1 and Hit=1. Writes to RO offsets are ignored.
REQ-017 PortOut is the PORT_OUT register, visible the cycle after the write edge.
REQ-018 PortIn passes through a 2-flop synchronizer (s1, s2) followed by a prev register; in_sync=s2.
REQ-019 A PortIn change is visible in PORT_IN after 2 edges; in_changed sets on the 3rd edge (s2 != prev).
REQ-020 STATUS clear: at an edge with MemRead=1, Hit=1 and offset 0x08, both status bits clear. The read returns the pre-clear value.
REQ-021 Set wins: a set event at the same edge as a STATUS clear leaves that bit set.
REQ-022 Timer state is idle when enable=0 and run when enable=1. Count changes only in run.
REQ-023 Run, count!=0: count decrements by 1 per edge.
REQ-024 Run, count==0 (terminal cycle):
  - timer_expired sets;
  - auto_reload=1: count loads TIMER_LOAD and enable stays 1 (period = LOAD+1 cycles);
  - auto_reload=0: enable clears to 0 (one-shot) and count stays 0.
REQ-025 A TIMER_LOAD write also copies WriteData into count at the same edge, overriding any decrement or reload.
REQ-026 A TIMER_CTRL write whose data has enable=1 starts counting from the current count on the next edge.
REQ-027 A TIMER_CTRL write at the terminal-cycle edge: the written value wins over the one-shot enable clear, while timer_expired still sets.
REQ-028 Count arithmetic is 32-bit unsigned with no wrap below 0.

Reset
REQ-029 While reset=1, asynchronously and regardless of clk, the following are 0: PORT_OUT, PortOut, s1, s2, prev, in_changed, timer_expired, TimerIRQ, TIMER_LOAD, enable, auto_reload, count.
REQ-030 The first edge after reset deassertion performs a normal update.
REQ-031 Reset asserted mid-count aborts the timer with no expiry flag.

Verification
REQ-032 Store 0xA5A5_0001 to BASE+0x00 -> PortOut = 0xA5A5_0001 the next cycle; load BASE+0x00 returns the same value; Hit=1.
REQ-033 Drive PortIn 0x00->0x3C -> PORT_IN reads 0x3C after 2 edges; STATUS=0x1 after 3 edges; load STATUS returns 0x1, and a second load returns 0x0.
REQ-034 TIMER_LOAD=3, TIMER_CTRL=0x3 -> TimerIRQ rises 4 edges after enable and repeats every 4 cycles; count sequence 3,2,1,0,3.
REQ-035 TIMER_LOAD=2, TIMER_CTRL=0x1 -> one expiry after 3 edges; enable reads 0 and count holds 0; no further expiry.
REQ-036 STATUS read coincident with the timer terminal cycle -> timer_expired remains 1 after the read edge.
REQ-037 Store to BASE+0x02 (misaligned) and to BASE+0x40 -> Hit=0, ReadData=0, no register changes; assert reset while count=5 -> all outputs 0 immediately and TimerIRQ never pulses.
